gf_inverse_seq: RTL and testbench
=================================

// Module: gf_inverse_seq
// PURPOSE
//   Parametrised GF(2^M) multiplicative inverter with valid/ready handshakes on input and output.
//   Computes inv(a) = a^(2^M-2) = prod_{k=1..M-1} a^(2^k) iteratively.
//   Each step uses one square and one multiply.
//   Sits in the RS decoder datapath (Forney / error-magnitude stage).
//   Replaces fixed 4-bit lookup tables when the symbol width or field polynomial changes.
// PARAMETERS
//   M     4      symbol width in bits; legal range 3..8
//   POLY  5'h13  field polynomial, M+1 bits, bit M set; default is x^4+x+1; must be irreducible
// PORTS
//   CLK        in   1  rising-edge clock; the block's only clock
//   RST        in   1  asynchronous, active-high reset
//   IN         in   M  operand a
//   IN_VALID   in   1  operand present
//   IN_READY   out  1  block can accept an operand
//   OUT        out  M  a^-1 (0 when a == 0)
//   OUT_VALID  out  1  OUT holds a result
//   OUT_READY  in   1  downstream accepts the result
//   DIV_ZERO   out  1  present only with GF_INV_DIV_ZERO_EN; see CONFIGURATION
// BEHAVIOUR
//   Reset (async, asserts immediately)
//     - state=IDLE; OUT=0; OUT_VALID=0; DIV_ZERO=0
//     - internal s, r, cnt cleared
//     - IN_READY=1 while in reset, since it decodes from IDLE
//   Reset mid-operation: any in-flight operand is discarded and no result is produced.
//   FSM: IDLE, CALC, DONE
//     - IDLE: IN_READY=1. On IN_VALID&IN_READY: s<=IN, r<=1, cnt<=0, state->CALC.
//     - CALC: IN_READY=0, OUT_VALID=0. Each edge: s<=s*s, r<=r*(s*s), cnt<=cnt+1.
//       When cnt==M-2: OUT<=r*(s*s), state->DONE. Exactly M-1 CALC edges.
//     - DONE: OUT_VALID=1. OUT and DIV_ZERO are held stable while OUT_READY=0, with no timeout.
//       On OUT_VALID&OUT_READY: state->IDLE, OUT_VALID falls on the next edge.
//   Pass-through accept
//     - IN_READY = (state==IDLE) | (state==DONE & OUT_READY)
//     - A simultaneous output handshake and input handshake in DONE goes straight to CALC with the new operand.
//   Latency: accept on edge 0 -> OUT_VALID high after edge M-1 (3 cycles for M=4).
//   Throughput: at most one result every M-1 cycles.
//   Arithmetic
//     - Multiply is polynomial shift-and-XOR with reduction by POLY after each shift.
//     - Purely combinational, M-bit in and M-bit out, with no intermediate width above M+1.
//     - Squaring reuses the same function.
//   a==0 yields OUT=0 naturally (s stays 0); no special path is needed.
//   IN is sampled only on the accept edge; IN changes at other times are ignored.
//   OUT_READY while OUT_VALID=0 has no effect.
//   IN_VALID held high in CALC is ignored until IN_READY rises.
// CONFIGURATION
//   GF_INV_DIV_ZERO_EN defined
//     - Adds output DIV_ZERO.
//     - Registered on the accept edge as (IN==0); valid only while OUT_VALID=1.
//     - Cleared by reset, held with OUT, and updated on a pass-through accept.
//   GF_INV_DIV_ZERO_EN undefined
//     - DIV_ZERO port and its register are absent.
//     - All other behaviour is identical.
// TESTING
//   1. M=4, POLY=0x13: IN=2 accepted on edge 0, OUT_READY=1 -> OUT_VALID after edge 3, OUT=9.
//      Then IDLE, IN_READY=1.
//   2. Exhaustive M=4, IN=1..15 -> OUT = 1,9,14,13,11,7,6,15,2,12,5,10,4,3,8.
//      Bench also checks IN*OUT==1 via a reference multiplier.
//   3. IN=0 -> OUT=0; with GF_INV_DIV_ZERO_EN, DIV_ZERO=1.
//      The next operand IN=3 gives OUT=14 with DIV_ZERO=0.
//   4. Backpressure: IN=7, OUT_READY=0 for 6 cycles.
//      - OUT=6 and OUT_VALID=1 held stable; IN_READY=0.
//      - On OUT_READY=1 with IN_VALID=1 and IN=5: pass-through accept, next OUT=11 three cycles later.
//   5. RST pulsed on the 2nd CALC cycle of IN=8.
//      - OUT=0, OUT_VALID=0, IN_READY=1 immediately; no result for 8 ever appears.
//      - A new IN=4 returns 13.
//   6. M=8, POLY=0x11B: IN=0x53 -> OUT=0xCA after 7 cycles; IN=0x01 -> 0x01; IN=0x02 -> 0x8D.

Source files
------------

// File: rtl/gf_inverse_seq.sv
// gf_inverse_seq: sequential GF(2^M) multiplicative inverter with
// valid/ready handshakes on both sides.
//
// It computes inv(a) = a^(2^M-2) = prod_{k=1..M-1} a^(2^k). Each CALC cycle
// does one square and one multiply, so a result takes M-1 cycles. An input
// of 0 naturally gives OUT = 0.
//
// Optional feature: define GF_INV_DIV_ZERO_EN to add the DIV_ZERO output.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous, active-high reset
//   IN         in   operand a (M bits)
//   IN_VALID   in   operand present
//   IN_READY   out  block can accept an operand (combinational decode)
//   OUT        out  a^-1 (M bits, registered)
//   OUT_VALID  out  OUT holds a result (registered)
//   OUT_READY  in   downstream accepts the result
//   DIV_ZERO   out  operand was 0; only with GF_INV_DIV_ZERO_EN
module gf_inverse_seq #(
  parameter int unsigned M    = 4,
  parameter logic [M:0]  POLY = (M+1)'('h13)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [M-1:0] IN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [M-1:0] OUT,
  output logic         OUT_VALID,
  input  logic         OUT_READY
`ifdef GF_INV_DIV_ZERO_EN
  ,
  output logic         DIV_ZERO
`endif
);

  localparam int unsigned CW = $clog2(M);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   s_q, r_q;
  logic [CW-1:0]  cnt_q;
  logic           accept, last;
  logic [M-1:0]   sq, prod;

  // Shift-and-XOR multiply, reducing by POLY after every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    logic [M:0]   t;
    p = '0;
    x = a;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) p = p ^ x;
      t = {x, 1'b0};
      if (t[M]) t = t ^ POLY;
      x = t[M-1:0];
    end
    return p;
  endfunction

  assign sq   = gf_mul(s_q, s_q);
  assign prod = gf_mul(r_q, sq);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake decode.
  always_comb begin
    state_d  = state_q;
    IN_READY = (state_q == IDLE) | ((state_q == DONE) & OUT_READY);
    accept   = IN_VALID & IN_READY;
    last     = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (OUT_READY) state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      if (accept) begin
        s_q   <= IN;
        r_q   <= M'(1);
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        s_q   <= sq;
        r_q   <= prod;
        cnt_q <= cnt_q + CW'(1);
        if (last) OUT <= prod;
      end
      OUT_VALID <= (state_d == DONE);
    end
  end

`ifdef GF_INV_DIV_ZERO_EN
  // Zero-operand flag travels with the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         DIV_ZERO <= 1'b0;
    else if (accept) DIV_ZERO <= (IN == '0);
  end
`endif

endmodule

// File: tb/tb_gf_inverse_seq.sv
module tb_gf_inverse_seq;

  logic       CLK;
  logic       RST;
  logic [3:0] IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
`ifdef GF_INV_DIV_ZERO_EN
  logic       DIV_ZERO;
  logic       DIV_ZERO8;
`endif

  logic [7:0] IN8;
  logic       IN_VALID8;
  logic       IN_READY8;
  logic [7:0] OUT8;
  logic       OUT_VALID8;
  logic       OUT_READY8;

  int tests_run;
  int tests_failed;

  logic [4:0] sb4[$];   // {div_zero, inverse}
  logic [7:0] sb8[$];

  gf_inverse_seq #(.M(4), .POLY(5'h13)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef GF_INV_DIV_ZERO_EN
    , .DIV_ZERO(DIV_ZERO)
`endif
  );

  gf_inverse_seq #(.M(8), .POLY(9'h11B)) dut8 (
    .CLK(CLK), .RST(RST), .IN(IN8), .IN_VALID(IN_VALID8), .IN_READY(IN_READY8),
    .OUT(OUT8), .OUT_VALID(OUT_VALID8), .OUT_READY(OUT_READY8)
`ifdef GF_INV_DIV_ZERO_EN
    , .DIV_ZERO(DIV_ZERO8)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference multiply: carry-less product, then reduce from the top bit down.
  function automatic int unsigned ref_mul(int unsigned a, int unsigned b, int unsigned m, int unsigned poly);
    int unsigned p;
    p = 0;
    for (int i = 0; i < int'(m); i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int k = 2 * int'(m) - 2; k >= int'(m); k--)
      if (((p >> k) & 1) != 0) p = p ^ (poly << (k - int'(m)));
    return p;
  endfunction

  // Drive an operand into the M=4 instance; returns after the accept edge.
  task automatic send4(input logic [3:0] a);
    int n;
    n = 0;
    IN = a;
    IN_VALID = 1'b1;
    #1;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (!IN_READY) begin
      tests_failed++;
      $display("FAIL send4_timeout: IN_READY stayed %b, required 1", IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN = 4'($urandom_range(0, 15));
  endtask

  // Wait (bounded) for OUT_VALID on the M=4 instance; optionally take the result.
  task automatic collect4(input int max_cyc, input bit consume, output logic [3:0] o,
                          output logic dz, output int cyc, output bit ok);
    ok = 0; cyc = 0; o = '0; dz = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge CLK); #1; cyc++;
      if (OUT_VALID) begin
        ok = 1;
        o = OUT;
`ifdef GF_INV_DIV_ZERO_EN
        dz = DIV_ZERO;
`endif
        break;
      end
    end
    if (ok && consume) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; IN = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN8 = '0; IN_VALID8 = 1'b0; OUT_READY8 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (OUT !== 4'h0) begin tests_failed++; $display("FAIL reset_out: got %h, required 0", OUT); end
    tests_run++;
    if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", OUT_VALID); end
    tests_run++;
    if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", IN_READY); end
`ifdef GF_INV_DIV_ZERO_EN
    tests_run++;
    if (DIV_ZERO !== 1'b0) begin tests_failed++; $display("FAIL reset_div_zero: got %b, required 0", DIV_ZERO); end
`endif
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single;
    logic [3:0] o; logic dz; int cyc; bit ok; logic [4:0] e;
    OUT_READY = 1'b1;
    send4(4'd2);
    sb4.push_back({1'b0, 4'd9});
    collect4(20, 1, o, dz, cyc, ok);
    e = sb4.pop_front();
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_timeout: no OUT_VALID, required one"); end
    tests_run++;
    if (o !== e[3:0]) begin tests_failed++; $display("FAIL single_out: got %h, required %h", o, e[3:0]); end
    tests_run++;
    if (cyc != 3) begin tests_failed++; $display("FAIL single_latency: got %0d, required 3", cyc); end
    tests_run++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1)
      begin tests_failed++; $display("FAIL single_idle: got valid=%b ready=%b, required 0/1", OUT_VALID, IN_READY); end
  endtask

  task automatic test_exhaustive;
    int exp_tab[16] = '{0, 1, 9, 14, 13, 11, 7, 6, 15, 2, 12, 5, 10, 4, 3, 8};
    logic [3:0] o; logic dz; int cyc; bit ok; logic [4:0] e;
    OUT_READY = 1'b1;
    for (int a = 1; a < 16; a++) begin
      send4(4'(a));
      sb4.push_back({1'b0, 4'(exp_tab[a])});
      collect4(20, 1, o, dz, cyc, ok);
      e = sb4.pop_front();
      tests_run++;
      if (!ok || o !== e[3:0])
        begin tests_failed++; $display("FAIL exh_out a=%0d: got %h ok=%0d, required %h", a, o, ok, e[3:0]); end
      tests_run++;
      if (ref_mul(a, int'(o), 4, 32'h13) != 1)
        begin tests_failed++; $display("FAIL exh_product a=%0d: a*out=%0d, required 1", a, ref_mul(a, int'(o), 4, 32'h13)); end
    end
  endtask

  task automatic test_zero;
    logic [3:0] o; logic dz; int cyc; bit ok; logic [4:0] e;
    OUT_READY = 1'b1;
    send4(4'd0);
    sb4.push_back({1'b1, 4'd0});
    collect4(20, 1, o, dz, cyc, ok);
    e = sb4.pop_front();
    tests_run++;
    if (!ok || o !== e[3:0]) begin tests_failed++; $display("FAIL zero_out: got %h ok=%0d, required %h", o, ok, e[3:0]); end
`ifdef GF_INV_DIV_ZERO_EN
    tests_run++;
    if (dz !== e[4]) begin tests_failed++; $display("FAIL zero_div_zero: got %b, required %b", dz, e[4]); end
`endif
    send4(4'd3);
    sb4.push_back({1'b0, 4'd14});
    collect4(20, 1, o, dz, cyc, ok);
    e = sb4.pop_front();
    tests_run++;
    if (!ok || o !== e[3:0]) begin tests_failed++; $display("FAIL zero_next_out: got %h ok=%0d, required %h", o, ok, e[3:0]); end
`ifdef GF_INV_DIV_ZERO_EN
    tests_run++;
    if (dz !== e[4]) begin tests_failed++; $display("FAIL zero_next_div_zero: got %b, required %b", dz, e[4]); end
`endif
  endtask

  task automatic test_backpressure;
    logic [3:0] o; logic dz; int cyc; bit ok; logic [4:0] e;
    OUT_READY = 1'b0;
    send4(4'd7);
    sb4.push_back({1'b0, 4'd6});
    collect4(20, 0, o, dz, cyc, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_timeout: no OUT_VALID, required one"); end
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      tests_run++;
      if (OUT !== 4'd6 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0)
        begin tests_failed++; $display("FAIL bp_hold cyc=%0d: got out=%h valid=%b ready=%b, required 6/1/0", i, OUT, OUT_VALID, IN_READY); end
    end
    e = sb4.pop_front();
    tests_run++;
    if (OUT !== e[3:0]) begin tests_failed++; $display("FAIL bp_out: got %h, required %h", OUT, e[3:0]); end
    IN = 4'd5; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1;
    tests_run++;
    if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL bp_passthru_ready: got %b, required 1", IN_READY); end
    sb4.push_back({1'b0, 4'd11});
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    tests_run++;
    if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_fall: got %b, required 0", OUT_VALID); end
    collect4(20, 1, o, dz, cyc, ok);
    e = sb4.pop_front();
    tests_run++;
    if (!ok || o !== e[3:0]) begin tests_failed++; $display("FAIL bp_next_out: got %h ok=%0d, required %h", o, ok, e[3:0]); end
    tests_run++;
    if (cyc != 3) begin tests_failed++; $display("FAIL bp_next_latency: got %0d, required 3", cyc); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] o; logic dz; int cyc; bit ok; logic [4:0] e; bit seen;
    OUT_READY = 1'b1;
    send4(4'd8);
    sb4.push_back({1'b0, 4'd15});
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    tests_run++;
    if (OUT !== 4'h0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1)
      begin tests_failed++; $display("FAIL rst_mid_async: got out=%h valid=%b ready=%b, required 0/0/1", OUT, OUT_VALID, IN_READY); end
    sb4.delete();
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen = 1;
    end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL rst_mid_ghost: got a result after reset, required none"); end
    send4(4'd4);
    sb4.push_back({1'b0, 4'd13});
    collect4(20, 1, o, dz, cyc, ok);
    e = sb4.pop_front();
    tests_run++;
    if (!ok || o !== e[3:0]) begin tests_failed++; $display("FAIL rst_mid_next: got %h ok=%0d, required %h", o, ok, e[3:0]); end
  endtask

  task automatic test_m8;
    logic [7:0] vin[3] = '{8'h53, 8'h01, 8'h02};
    logic [7:0] vexp[3] = '{8'hCA, 8'h01, 8'h8D};
    logic [7:0] e, o;
    int n, cyc;
    bit ok;
    OUT_READY8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      IN8 = vin[k]; IN_VALID8 = 1'b1;
      n = 0;
      #1;
      while (!IN_READY8 && n < 50) begin @(posedge CLK); #1; n++; end
      @(posedge CLK); #1;
      IN_VALID8 = 1'b0;
      IN8 = 8'($urandom_range(0, 255));
      sb8.push_back(vexp[k]);
      ok = 0; cyc = 0; o = '0;
      for (int i = 0; i < 30; i++) begin
        @(posedge CLK); #1; cyc++;
        if (OUT_VALID8) begin ok = 1; o = OUT8; break; end
      end
      e = sb8.pop_front();
      tests_run++;
      if (!ok || o !== e) begin tests_failed++; $display("FAIL m8_out in=%h: got %h ok=%0d, required %h", vin[k], o, ok, e); end
      tests_run++;
      if (cyc != 7) begin tests_failed++; $display("FAIL m8_latency in=%h: got %0d, required 7", vin[k], cyc); end
      tests_run++;
      if (ref_mul(int'(vin[k]), int'(o), 8, 32'h11B) != 1)
        begin tests_failed++; $display("FAIL m8_product in=%h: a*out=%0d, required 1", vin[k], ref_mul(int'(vin[k]), int'(o), 8, 32'h11B)); end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_exhaustive();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_m8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
